// File: rtl/udp_rx_demux.sv
// udp_rx_demux: strips the UDP header, validates the length and demuxes the payload
// to a channel tag chosen by destination port, with full AXI-Stream backpressure.
module udp_rx_demux #(
   parameter int NUM_CH = 4,
   parameter int CH_W = 2,
   parameter logic [NUM_CH*16-1:0] PORT_LIST = {16'd4003, 16'd4002, 16'd4001, 16'd4000},
   parameter bit ENABLE_FILTER = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      s_axis_tdata,
   input  logic            s_axis_tvalid,
   input  logic            s_axis_tlast,
   output logic            s_axis_tready,
   output logic [7:0]      m_axis_tdata,
   output logic            m_axis_tvalid,
   output logic            m_axis_tlast,
   output logic [CH_W-1:0] m_axis_tdest,
   input  logic            m_axis_tready,
   output logic [15:0]     src_port_out,
   output logic [15:0]     dst_port_out,
   output logic [15:0]     len_out,
   output logic            hdr_valid,
   output logic            err_len,
   output logic            err_hdr,
   output logic [15:0]     pkt_cnt,
   output logic [15:0]     drop_cnt
);
   typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN} state_t;
   state_t state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [47:0] hdr_q, hdr_d;
   logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, rem_q, rem_d;
   logic [15:0] pkt_q, pkt_d, drop_q, drop_d;
   logic [CH_W-1:0] tdest_q, tdest_d, mdest_q, mdest_d, hit_idx;
   logic [7:0] mdata_q, mdata_d;
   logic mvalid_q, mvalid_d, mlast_q, mlast_d;
   logic hv_q, hv_d, el_q, el_d, eh_q, eh_d;
   logic acc, hit, pkt_inc, drop_inc;
   logic [15:0] hdr_rem;
   // Scan from the top so the lowest matching channel index wins
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (hdr_q[31:16] == PORT_LIST[16*i +: 16]) begin
            hit = 1'b1;
            hit_idx = CH_W'(i);
         end
   end
   assign s_axis_tready = reset & ((state_q != PAYLOAD) | !mvalid_q | m_axis_tready);
   assign acc = s_axis_tvalid & s_axis_tready;
   assign hdr_rem = hdr_q[15:0] - 16'd8;
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      hdr_d = hdr_q;
      src_d = src_q;
      dst_d = dst_q;
      len_d = len_q;
      rem_d = rem_q;
      tdest_d = tdest_q;
      mdest_d = mdest_q;
      mdata_d = mdata_q;
      mvalid_d = mvalid_q & !m_axis_tready;
      mlast_d = mlast_q;
      hv_d = 1'b0;
      el_d = 1'b0;
      eh_d = 1'b0;
      pkt_inc = 1'b0;
      drop_inc = 1'b0;
      case (state_q)
         HDR: if (acc) begin
            idx_d = idx_q + 3'd1;
            if (idx_q < 3'd6) hdr_d = {hdr_q[39:0], s_axis_tdata};
            if (idx_q == 3'd7) begin
               idx_d = '0;
               hv_d = 1'b1;
               src_d = hdr_q[47:32];
               dst_d = hdr_q[31:16];
               len_d = hdr_q[15:0];
               rem_d = hdr_rem;
               state_d = s_axis_tlast ? HDR : DRAIN;
               if (hdr_q[15:0] < 16'd8) begin
                  el_d = 1'b1;
                  drop_inc = 1'b1;
               end else if (ENABLE_FILTER && !hit) drop_inc = 1'b1;
               else if (hdr_rem == 16'd0) pkt_inc = 1'b1;
               else if (s_axis_tlast) begin
                  el_d = 1'b1;
                  drop_inc = 1'b1;
               end else begin
                  state_d = PAYLOAD;
                  tdest_d = ENABLE_FILTER ? hit_idx : '0;
               end
            end else if (s_axis_tlast) begin
               idx_d = '0;
               eh_d = 1'b1;
               drop_inc = 1'b1;
            end
         end
         PAYLOAD: if (acc) begin
            mdata_d = s_axis_tdata;
            mvalid_d = 1'b1;
            mlast_d = (rem_q == 16'd1) | s_axis_tlast;
            mdest_d = tdest_q;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
               pkt_inc = 1'b1;
               state_d = s_axis_tlast ? HDR : DRAIN;
            end else if (s_axis_tlast) begin
               el_d = 1'b1;
               pkt_inc = 1'b1;
               state_d = HDR;
            end
         end
         DRAIN: if (acc && s_axis_tlast) state_d = HDR;
         default: state_d = HDR;
      endcase
      pkt_d = (pkt_inc && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
      drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HDR;
         idx_q <= '0;
         hdr_q <= '0;
         src_q <= '0;
         dst_q <= '0;
         len_q <= '0;
         rem_q <= '0;
         tdest_q <= '0;
         mdest_q <= '0;
         mdata_q <= '0;
         mvalid_q <= 1'b0;
         mlast_q <= 1'b0;
         hv_q <= 1'b0;
         el_q <= 1'b0;
         eh_q <= 1'b0;
         pkt_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         hdr_q <= hdr_d;
         src_q <= src_d;
         dst_q <= dst_d;
         len_q <= len_d;
         rem_q <= rem_d;
         tdest_q <= tdest_d;
         mdest_q <= mdest_d;
         mdata_q <= mdata_d;
         mvalid_q <= mvalid_d;
         mlast_q <= mlast_d;
         hv_q <= hv_d;
         el_q <= el_d;
         eh_q <= eh_d;
         pkt_q <= pkt_d;
         drop_q <= drop_d;
      end
   end
   assign m_axis_tdata = mdata_q;
   assign m_axis_tvalid = mvalid_q;
   assign m_axis_tlast = mlast_q;
   assign m_axis_tdest = mdest_q;
   assign src_port_out = src_q;
   assign dst_port_out = dst_q;
   assign len_out = len_q;
   assign hdr_valid = hv_q;
   assign err_len = el_q;
   assign err_hdr = eh_q;
   assign pkt_cnt = pkt_q;
   assign drop_cnt = drop_q;
endmodule

// File: tb/tb_udp_rx_demux.sv
// tb_udp_rx_demux: directed frames with hand-computed beats, pulses and counters.
module tb_udp_rx_demux;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [7:0] s_axis_tdata = '0;
   logic s_axis_tvalid = 1'b0;
   logic s_axis_tlast = 1'b0;
   logic s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tlast;
   logic [1:0] m_axis_tdest;
   logic m_axis_tready = 1'b1;
   logic [15:0] src_port_out, dst_port_out, len_out, pkt_cnt, drop_cnt;
   logic hdr_valid, err_len, err_hdr;
   int checks = 0;
   int errors = 0;
   int hv_n = 0, el_n = 0, eh_n = 0;
   int hv0, el0, eh0;
   logic tog = 1'b0;
   logic [10:0] got[$];
   logic [10:0] exp_q[$];
   logic [7:0] frm[$];
   logic prev_stall = 1'b0;
   logic [10:0] prev_beat = '0;
   udp_rx_demux dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
      .src_port_out(src_port_out), .dst_port_out(dst_port_out), .len_out(len_out),
      .hdr_valid(hdr_valid), .err_len(err_len), .err_hdr(err_hdr),
      .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      m_axis_tready = tog ? ~m_axis_tready : 1'b1;
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Outputs and inputs are both stable at the falling edge
   always @(negedge clk) begin
      if (reset) begin
         if (prev_stall)
            check("stable", {21'd0, m_axis_tvalid, m_axis_tdest, m_axis_tlast, m_axis_tdata}, {21'd0, 1'b1, prev_beat});
         if (m_axis_tvalid && !m_axis_tready && !m_axis_tlast) check("s_ready_stall", 32'(s_axis_tready), 32'd0);
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat = {m_axis_tdest, m_axis_tlast, m_axis_tdata};
         if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tdest, m_axis_tlast, m_axis_tdata});
         hv_n += int'(hdr_valid);
         el_n += int'(err_len);
         eh_n += int'(err_hdr);
      end else prev_stall = 1'b0;
   end
   task automatic mk(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      frm.delete();
      frm.push_back(s[15:8]); frm.push_back(s[7:0]);
      frm.push_back(d[15:8]); frm.push_back(d[7:0]);
      frm.push_back(l[15:8]); frm.push_back(l[7:0]);
      frm.push_back(8'h00); frm.push_back(8'h00);
   endtask
   task automatic send_frm(input bit last_en);
      bit ok;
      int n;
      for (int k = 0; k < frm.size(); k++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata = frm[k];
         s_axis_tlast = last_en && (k == frm.size() - 1);
         n = 0;
         do begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
         end while (!ok && n < 200);
         if (!ok) begin
            errors++;
            $display("FAIL send_timeout: s_axis_tready stuck at 0, required 1");
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
   endtask
   task automatic idle();
      repeat (8) @(posedge clk);
      #1;
   endtask
   task automatic ex(input logic [1:0] d, input logic l, input logic [7:0] b);
      exp_q.push_back({d, l, b});
   endtask
   task automatic chk_beats(input string tag);
      check({tag, "_n"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, 32'(got[i]), 32'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask
   task automatic frame1();
      mk(16'd1234, 16'd4001, 16'd12);
      frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
      send_frm(1'b1);
      idle();
      ex(2'd1, 1'b0, 8'hDE); ex(2'd1, 1'b0, 8'hAD); ex(2'd1, 1'b0, 8'hBE); ex(2'd1, 1'b1, 8'hEF);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_sready", 32'(s_axis_tready), 32'd0);
      check("rst_pkt", 32'(pkt_cnt), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      reset = 1'b1;
      #1;
      check("rel_sready", 32'(s_axis_tready), 32'd1);
      hv0 = hv_n; el0 = el_n;
      frame1();
      chk_beats("t1_beats");
      check("t1_hv", 32'(hv_n - hv0), 32'd1);
      check("t1_el", 32'(el_n - el0), 32'd0);
      check("t1_pkt", 32'(pkt_cnt), 32'd1);
      check("t1_src", 32'(src_port_out), 32'd1234);
      check("t1_dst", 32'(dst_port_out), 32'd4001);
      check("t1_len", 32'(len_out), 32'd12);
      tog = 1'b1;
      frame1();
      tog = 1'b0;
      idle();
      chk_beats("t2_beats");
      check("t2_pkt", 32'(pkt_cnt), 32'd2);
      mk(16'd1234, 16'd5555, 16'd10);
      frm.push_back(8'h01); frm.push_back(8'h02);
      send_frm(1'b1);
      idle();
      chk_beats("t3_drop_beats");
      check("t3_drop", 32'(drop_cnt), 32'd1);
      check("t3_pkt", 32'(pkt_cnt), 32'd2);
      frame1();
      chk_beats("t3_next_beats");
      check("t3_next_pkt", 32'(pkt_cnt), 32'd3);
      el0 = el_n;
      mk(16'd1000, 16'd4000, 16'd10);
      frm.push_back(8'h11); frm.push_back(8'h22);
      repeat (4) frm.push_back(8'h00);
      send_frm(1'b1);
      idle();
      ex(2'd0, 1'b0, 8'h11); ex(2'd0, 1'b1, 8'h22);
      chk_beats("t4_beats");
      check("t4_el", 32'(el_n - el0), 32'd0);
      check("t4_pkt", 32'(pkt_cnt), 32'd4);
      check("t4_drop", 32'(drop_cnt), 32'd1);
      el0 = el_n;
      mk(16'd1000, 16'd4002, 16'd20);
      frm.push_back(8'h31); frm.push_back(8'h32); frm.push_back(8'h33);
      send_frm(1'b1);
      idle();
      ex(2'd2, 1'b0, 8'h31); ex(2'd2, 1'b0, 8'h32); ex(2'd2, 1'b1, 8'h33);
      chk_beats("t5_beats");
      check("t5_el", 32'(el_n - el0), 32'd1);
      check("t5_pkt", 32'(pkt_cnt), 32'd5);
      check("t5_drop", 32'(drop_cnt), 32'd1);
      hv0 = hv_n; eh0 = eh_n;
      mk(16'd1000, 16'd4002, 16'd20);
      frm = frm[0:4];
      send_frm(1'b1);
      idle();
      chk_beats("t5h_beats");
      check("t5h_eh", 32'(eh_n - eh0), 32'd1);
      check("t5h_hv", 32'(hv_n - hv0), 32'd0);
      check("t5h_drop", 32'(drop_cnt), 32'd2);
      hv0 = hv_n;
      mk(16'd1000, 16'd4003, 16'd8);
      send_frm(1'b1);
      idle();
      chk_beats("t6z_beats");
      check("t6z_hv", 32'(hv_n - hv0), 32'd1);
      check("t6z_pkt", 32'(pkt_cnt), 32'd6);
      el0 = el_n;
      mk(16'd1000, 16'd4003, 16'd6);
      send_frm(1'b1);
      idle();
      chk_beats("t6s_beats");
      check("t6s_el", 32'(el_n - el0), 32'd1);
      check("t6s_drop", 32'(drop_cnt), 32'd3);
      check("t6s_pkt", 32'(pkt_cnt), 32'd6);
      mk(16'd1000, 16'd4001, 16'd20);
      repeat (5) frm.push_back(8'h5A);
      send_frm(1'b0);
      #2 reset = 1'b0;
      #1;
      check("t6r_mvalid", 32'(m_axis_tvalid), 32'd0);
      check("t6r_pkt", 32'(pkt_cnt), 32'd0);
      check("t6r_drop", 32'(drop_cnt), 32'd0);
      check("t6r_src", 32'(src_port_out), 32'd0);
      check("t6r_len", 32'(len_out), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      got.delete();
      el0 = el_n; eh0 = eh_n;
      frame1();
      chk_beats("t6a_beats");
      check("t6a_pkt", 32'(pkt_cnt), 32'd1);
      check("t6a_drop", 32'(drop_cnt), 32'd0);
      check("t6a_el", 32'(el_n - el0), 32'd0);
      check("t6a_eh", 32'(eh_n - eh0), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
